// File: rtl/pipe_skid_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg_pkg
//   Shared definitions for the elastic pipeline-stage register.
//   - N          : base machine word width already used across the core
//   - DATA_W_DEF : default payload width (pc concatenated with instruction)
//   - CNT_W_DEF  : default width of the performance stall counter
//   - pipe_state_t : occupancy of the 2-entry skid buffer
// ---------------------------------------------------------------------------
package pipe_skid_reg_pkg;

  localparam int N          = 32;
  localparam int DATA_W_DEF = 2 * N;
  localparam int CNT_W_DEF  = 16;

  // EMPTY: nothing held, BUSY: main entry valid, FULL: main and skid valid
  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_BUSY,
    PS_FULL
  } pipe_state_t;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Generic saturating up-counter for performance monitoring.
//   Ports:
//     clk  - clock
//     rstn - synchronous active-low reset, clears the count
//     inc  - count one event this cycle
//     clr  - clear the count (wins over inc)
//     cnt  - current count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear has priority; once all-ones the counter stays there so software
  // can tell a saturated reading from a wrapped one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   Elastic valid/ready pipeline-stage register built on a 2-entry skid
//   buffer. in_ready is decoded only from the state register, so there is no
//   combinational path from out_ready back to in_ready, yet one beat per cycle
//   can still stream through.
//   Ports:
//     clk, rstn  - clock, synchronous active-low reset
//     flush      - drop held entries and any beat accepted this cycle
//     in_valid   - upstream beat valid
//     in_ready   - stage can accept a beat (from registers)
//     in_data    - upstream payload
//     out_valid  - downstream beat valid
//     out_ready  - downstream accepts the beat
//     out_data   - downstream payload, zero whenever out_valid is low
//     stall_clr  - clear the stall counter
//     stall_cnt  - saturating count of cycles with out_valid & !out_ready
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = (state != PS_FULL);
  assign out_valid = (state != PS_EMPTY);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Occupancy FSM. main_q is always the head of the queue and skid_q only
  // catches the beat that arrives while the head is stalled. Vacated entries
  // are zeroed so out_data reads as zero whenever no beat is valid. Flush
  // overrides every transition, including an accepted incoming beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= PS_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= PS_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            state  <= PS_BUSY;
            main_q <= in_data;
          end
        end
        PS_BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= PS_FULL;
            skid_q <= in_data;
          end else if (out_fire) begin
            state  <= PS_EMPTY;
            main_q <= '0;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            state  <= PS_BUSY;
            main_q <= skid_q;
            skid_q <= '0;
          end
        end
        default: begin
          state  <= PS_EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (out_valid & ~out_ready),
    .clr  (stall_clr),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Self-checking bench for pipe_skid_reg. The reference model is a bounded
//   queue of capacity two plus an integer stall count; expected outputs are
//   derived from the queue contents.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int DATA_W  = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rstn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              stall_clr;
  logic [CNT_W-1:0]  stall_cnt;

  int nTests = 0;
  int nFail  = 0;

  logic [DATA_W-1:0] mq[$];
  int                mcnt = 0;

  pipe_skid_reg #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs derived from the model queue.
  function automatic logic exp_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic exp_ready();
    return mq.size() < 2;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data();
    if (mq.size() > 0) return mq[0];
    return '0;
  endfunction

  // Advance one clock edge and update the model with the handshakes that
  // occurred at that edge, then settle 1 time unit past the edge.
  task automatic tick();
    bit inf, outf, stl;
    inf  = in_valid && (mq.size() < 2);
    outf = (mq.size() > 0) && out_ready;
    stl  = (mq.size() > 0) && !out_ready;
    @(posedge clk);
    if (!rstn) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (flush) begin
        mq.delete();
      end else begin
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(in_data);
      end
      if (stall_clr) mcnt = 0;
      else if (stl && mcnt < CNT_MAX) mcnt++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall_clr = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    tick();
    in_data   = 16'h2222;
    tick();
    in_valid  = 1'b0;
    tick();
    nTests++;
    if (in_ready !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_prefull_ready: got %b expected 0", in_ready);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    nTests++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    nTests++;
    if (out_data !== 16'h0) begin
      nFail++;
      $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data);
    end
    nTests++;
    if (in_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    nTests++;
    if (stall_cnt !== 4'd0) begin
      nFail++;
      $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] beats[3];
    beats[0] = 16'h000A;
    beats[1] = 16'h000B;
    beats[2] = 16'h000C;
    drain();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = beats[i];
      tick();
      nTests++;
      if (out_valid !== 1'b1 || out_data !== beats[i]) begin
        nFail++;
        $display("[TB] FAIL stream_data[%0d]: got v=%b %h expected v=1 %h",
                 i, out_valid, out_data, beats[i]);
      end
      nTests++;
      if (in_ready !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, in_ready);
      end
    end
    in_valid = 1'b0;
    tick();
    nTests++;
    if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      nFail++;
      $display("[TB] FAIL stream_empty: got v=%b %h expected v=0 0000", out_valid, out_data);
    end
  endtask

  task automatic test_backpressure();
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    tick();
    in_data   = 16'h000B;
    tick();
    nTests++;
    if (in_ready !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL bp_full_ready: got %b expected 0", in_ready);
    end
    // Source holds 0xC while the stage is full.
    in_data = 16'h000C;
    tick();
    tick();
    nTests++;
    if (out_data !== 16'h000A || in_ready !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL bp_hold: got %h rdy=%b expected 000a rdy=0", out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    nTests++;
    if (out_data !== 16'h000B || in_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL bp_release1: got %h rdy=%b expected 000b rdy=1", out_data, in_ready);
    end
    tick();
    nTests++;
    if (out_data !== 16'h000C || out_valid !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL bp_release2: got v=%b %h expected v=1 000c", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
    nTests++;
    if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      nFail++;
      $display("[TB] FAIL bp_drained: got v=%b %h expected v=0 0000", out_valid, out_data);
    end
  endtask

  task automatic test_flush();
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0031;
    tick();
    in_data   = 16'h0032;
    tick();
    in_valid  = 1'b0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    nTests++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL flush_full: got v=%b %h rdy=%b expected v=0 0000 rdy=1",
               out_valid, out_data, in_ready);
    end
    in_valid = 1'b1;
    in_data  = 16'h0041;
    tick();
    in_data  = 16'h000D;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    nTests++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL flush_busy: got v=%b %h rdy=%b expected v=0 0000 rdy=1",
               out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nTests++;
      if (out_valid !== 1'b0 || out_data === 16'h000D) begin
        nFail++;
        $display("[TB] FAIL flush_no_ghost[%0d]: got v=%b %h expected v=0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001;
    tick();
    in_data   = 16'h0002;
    out_ready = 1'b1;
    nTests++;
    if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
      nFail++;
      $display("[TB] FAIL b2b_head: got v=%b %h expected v=1 0001", out_valid, out_data);
    end
    tick();
    in_valid = 1'b0;
    nTests++;
    if (out_valid !== 1'b1 || out_data !== 16'h0002 || in_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL b2b_next: got v=%b %h rdy=%b expected v=1 0002 rdy=1",
               out_valid, out_data, in_ready);
    end
    tick();
    nTests++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL b2b_drained: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_stall_counter();
    drain();
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0055;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    nTests++;
    if (stall_cnt !== 4'd15) begin
      nFail++;
      $display("[TB] FAIL stall_saturate: got %0d expected 15", stall_cnt);
    end
    nTests++;
    if (int'(stall_cnt) !== mcnt) begin
      nFail++;
      $display("[TB] FAIL stall_model: got %0d expected %0d", stall_cnt, mcnt);
    end
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    nTests++;
    if (stall_cnt !== 4'd0) begin
      nFail++;
      $display("[TB] FAIL stall_clear: got %0d expected 0", stall_cnt);
    end
    tick();
    nTests++;
    if (stall_cnt !== 4'd1) begin
      nFail++;
      $display("[TB] FAIL stall_restart: got %0d expected 1", stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = DATA_W'($urandom);
      flush     = ($urandom_range(0, 99) < 4);
      stall_clr = ($urandom_range(0, 99) < 3);
      tick();
      nTests++;
      if (out_valid !== exp_valid() || out_data !== exp_data() ||
          in_ready !== exp_ready() || int'(stall_cnt) !== mcnt) begin
        nFail++;
        $display("[TB] FAIL random[%0d]: got v=%b d=%h r=%b c=%0d expected v=%b d=%h r=%b c=%0d",
                 i, out_valid, out_data, in_ready, stall_cnt,
                 exp_valid(), exp_data(), exp_ready(), mcnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    #1;
    tick();
    tick();
    rstn = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_stall_counter();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline-stage register that replaces the fixed freeze/flush inter-stage registers (IF/ID, ID/EX, ...) with a valid/ready handshake.
- Built around a 2-entry skid buffer, so in_ready is registered and there is no combinational path from out_ready to in_ready.
- Keeps full throughput: one transfer per cycle.
- Supports synchronous flush (bubble insertion) and a saturating downstream-stall counter for performance monitoring.

Parameters:
DATA_W, 2*N, width of the payload (e.g. pc concatenated with instruction)
CNT_W, 16, width of the stall counter

Ports:
clk  input  1  clock
rstn  input  1  reset
flush  input  1  discard all held entries and the incoming beat this cycle
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat (registered)
in_data  input  DATA_W  upstream payload
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat
out_data  output  DATA_W  downstream payload
stall_clr  input  1  clear the stall counter
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset: rstn, synchronous, active-low; clock clk. While rstn=0, on each clk edge:
  - state<=PS_EMPTY; main and skid data <= '0; stall_cnt<='0.
  - Outputs after the edge: out_valid=0, out_data=0, in_ready=1.
  - Applies regardless of current state, including mid-transfer.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State (pipe_state_t), transitions after reset; flush has priority over all:
  - PS_EMPTY:
    - in_fire -> PS_BUSY, main<=in_data.
    - Otherwise stay.
  - PS_BUSY:
    - in_fire & out_fire -> PS_BUSY, main<=in_data.
    - in_fire only -> PS_FULL, skid<=in_data.
    - out_fire only -> PS_EMPTY, main<='0.
    - Neither -> hold.
  - PS_FULL:
    - out_fire -> PS_BUSY, main<=skid, skid<='0.
    - Otherwise hold.
    - in_fire is impossible because in_ready=0.
- Output decode (all purely from registers):
  - in_ready = (state != PS_FULL).
  - out_valid = (state != PS_EMPTY).
  - out_data = main.
- Latency: a beat accepted at edge k is presented on out_data after edge k (1 cycle) when the stage is empty or out_ready=1.
- Ordering: strict FIFO; no beat is duplicated or lost except by flush.
- Zero-bubble convention: out_data=0 whenever out_valid=0.
- flush=1 (rstn=1):
  - Next state PS_EMPTY; main and skid <= '0.
  - in_ready is unaffected in the flush cycle. A beat handshaken in that cycle counts as consumed upstream but is discarded.
  - An out_fire in the flush cycle is a valid transfer.
- Stall counter:
  - Each edge with out_valid & !out_ready: stall_cnt += 1, saturating at all-ones.
  - stall_clr=1 -> stall_cnt<='0; this takes priority over increment.
  - flush does not affect stall_cnt.
- Data in invalid slots is never observable; in_data is sampled only on in_fire.

Decomposition:
- Package defines gets `typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t;`. DATA_W defaults from the existing N.
- One sub-module, sat_counter (parameter W; inputs inc, clr; output cnt), used for stall_cnt and reusable by other perf counters.

Test Plan:
- Reset from PS_FULL with out_ready=0, rstn=0 for 1 edge -> out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, in_data 0xA,0xB,0xC on consecutive cycles -> out_data 0xA,0xB,0xC on the following three cycles, in_ready always 1.
- Backpressure: out_ready=0, push 0xA,0xB -> in_ready=0 after the 0xB edge and 0xC is held by the source. Then out_ready=1 -> 0xA,0xB,0xC in order, with in_ready back at 1 one cycle after the first out_fire.
- Flush in PS_FULL with in_valid=0, then flush in PS_BUSY with in_valid=1 data 0xD -> each case: next cycle out_valid=0, out_data=0, in_ready=1, and 0xD never appears.
- Simultaneous in_fire/out_fire in PS_BUSY holding 0x1 with input 0x2 -> 0x1 transferred, out_data=0x2, state stays PS_BUSY.
- Stall counter with CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15. Then stall_clr=1 together with a stall cycle -> stall_cnt=0.
